// File: rtl/bram_burst_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_burst_reader_if
//  Description : Valid/ready stream bundle carrying burst data words and an
//                end-of-burst marker out of bram_burst_reader.
//  Revision    : 1.0  initial release
// ============================================================================
interface bram_burst_reader_if #(
   parameter int RAM_WIDTH = 16
);
   logic                 valid;
   logic                 ready;
   logic [RAM_WIDTH-1:0] data;
   logic                 last;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface
`default_nettype wire

// File: rtl/bram_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : bram_burst_reader
//  Description : Reads a burst of consecutive words (wrapping at the end of
//                the RAM) from a 1-cycle-latency block RAM and streams them
//                out on a valid/ready interface with full backpressure.
//                A 2-entry skid FIFO plus a credit check on every read keeps
//                the pipeline lossless at 1 beat/cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module bram_burst_reader #(
   parameter int RAM_WIDTH  = 16,
   parameter int ADDR_WIDTH = 10,
   parameter int RAM_DEPTH  = 1024
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic                  i_start,
   input  wire logic [ADDR_WIDTH-1:0] i_base_addr,
   input  wire logic [ADDR_WIDTH:0]   i_length,
   output      logic                  o_busy,
   output      logic                  o_done,
   output      logic                  o_bram_rd_en,
   output      logic [ADDR_WIDTH-1:0] o_bram_addr,
   input  wire logic [RAM_WIDTH-1:0]  i_bram_dout,
   bram_burst_reader_if.master        m
);

   localparam logic [ADDR_WIDTH:0] c_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

   // Address arithmetic relies on natural wrap of an ADDR_WIDTH-bit sum.
   generate
      if (RAM_DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
         $error("RAM_DEPTH must equal 2**ADDR_WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH:0]   r_len;
   logic [ADDR_WIDTH:0]   r_issued;
   logic [ADDR_WIDTH:0]   r_accepted;
   logic                  r_inflight;
   logic [RAM_WIDTH-1:0]  r_fifo [2];
   logic                  r_wptr;
   logic                  r_rptr;
   logic [1:0]            r_occ;

   logic                  w_valid;
   logic                  w_pop;
   logic [2:0]            w_credit;
   logic                  w_rd_en;
   logic                  w_last_issue;
   logic                  w_last_pop;
   logic                  w_accept_start;

   // Handshake, credit and issue decisions for the current cycle.
   always_comb begin
      w_valid        = (r_occ != 2'd0);
      w_pop          = w_valid & m.ready;
      // Words that will be buffered or in flight after this edge, before any new read.
      w_credit       = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
      w_rd_en        = (r_state == S_RUN) && (r_issued < r_len) && (w_credit < 3'd2);
      w_last_issue   = w_rd_en && (r_issued == (r_len - c_one));
      w_last_pop     = w_pop && (r_accepted == (r_len - c_one));
      w_accept_start = (r_state == S_IDLE) && i_start;
   end

   // Next-state selection.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = (i_length == '0) ? S_DONE : S_RUN;
         S_RUN:   if (w_last_issue) w_next = S_DRAIN;
         S_DRAIN: if (w_last_pop) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register; reset abandons any burst in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Burst descriptor capture and issue/accept counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base     <= '0;
         r_len      <= '0;
         r_issued   <= '0;
         r_accepted <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
         if (w_accept_start) begin
            r_base     <= i_base_addr;
            r_len      <= i_length;
            r_issued   <= '0;
            r_accepted <= '0;
         end else begin
            if (w_rd_en) r_issued   <= r_issued + c_one;
            if (w_pop)   r_accepted <= r_accepted + c_one;
         end
      end
   end

   // Two-entry FIFO catching the word that arrives the cycle after each read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fifo[0] <= '0;
         r_fifo[1] <= '0;
         r_wptr    <= 1'b0;
         r_rptr    <= 1'b0;
         r_occ     <= 2'd0;
      end else begin
         if (r_inflight) begin
            r_fifo[r_wptr] <= i_bram_dout;
            r_wptr         <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      end
   end

   // Output drive: BRAM port is combinational, stream comes from the FIFO head.
   always_comb begin
      o_bram_rd_en = w_rd_en;
      o_bram_addr  = r_base + r_issued[ADDR_WIDTH-1:0];
      o_busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
      o_done       = (r_state == S_DONE);
      m.valid      = w_valid;
      m.data       = r_fifo[r_rptr];
      m.last       = w_valid && (r_accepted == (r_len - c_one));
   end

endmodule
`default_nettype wire

// File: tb/tb_bram_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_burst_reader
//  Description : Scoreboard bench for bram_burst_reader: BRAM model, random
//                backpressure, expected addresses/words queued at start and
//                consumed by an independent negedge monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bram_burst_reader;
   localparam int RW    = 16;
   localparam int AW    = 10;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic [AW-1:0] i_base = '0;
   logic [AW:0]   i_len = '0;
   logic          o_busy, o_done, rd_en;
   logic [AW-1:0] addr;
   logic [RW-1:0] dout = '0;

   bram_burst_reader_if #(.RAM_WIDTH(RW)) sif ();

   bram_burst_reader #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (i_start),
      .i_base_addr  (i_base),
      .i_length     (i_len),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_bram_rd_en (rd_en),
      .o_bram_addr  (addr),
      .i_bram_dout  (dout),
      .m            (sif.master)
   );

   initial forever #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail = 0;
   logic [RW-1:0] mem [DEPTH];
   logic [RW-1:0] q_data [$];
   bit            q_last [$];
   logic [AW-1:0] q_addr [$];
   int            rd_cnt = 0;
   int            acc_cnt = 0;
   bit            stall_prev = 0;
   logic [RW-1:0] stall_data = '0;
   bit            expect_done = 0;
   int            rmode = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   // Block RAM model with one cycle of registered read latency.
   initial forever begin
      @(posedge clk);
      if (rd_en) dout <= mem[addr];
   end

   // Consumer ready pattern: 0 always, 1 random, 2 toggling, 3 held low.
   initial begin
      sif.ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       sif.ready = 1'b1;
            1:       sif.ready = 1'($urandom_range(0, 1));
            2:       sif.ready = ~sif.ready;
            default: sif.ready = 1'b0;
         endcase
      end
   end

   // Monitor: compares every read address and accepted beat against the queues.
   initial forever begin
      bit pop;
      bit l;
      @(negedge clk);
      if (rst_n) begin
         pop = sif.valid && sif.ready;
         if (expect_done) begin
            chk("done_after_last", 32'(o_done), 1);
            expect_done = 0;
         end
         if (stall_prev) begin
            chk("stall_valid_held", 32'(sif.valid), 1);
            chk("stall_data_stable", 32'(sif.data), 32'(stall_data));
         end
         stall_prev = sif.valid && !sif.ready;
         stall_data = sif.data;
         if (rd_en) begin
            chk("credit_limit", 32'((rd_cnt - acc_cnt + 1 - int'(pop)) <= 2), 1);
            if (q_addr.size() == 0) fail("unexpected_read");
            else chk("bram_addr", 32'(addr), 32'(q_addr.pop_front()));
            rd_cnt++;
         end
         if (pop) begin
            if (q_data.size() == 0) fail("unexpected_beat");
            else begin
               chk("m_data", 32'(sif.data), 32'(q_data.pop_front()));
               l = q_last.pop_front();
               chk("m_last", 32'(sif.last), 32'(l));
               if (l) expect_done = 1;
            end
            acc_cnt++;
         end
      end
   end

   task automatic start_burst(input int b, input int l);
      @(posedge clk);
      #1;
      i_start = 1'b1;
      i_base  = AW'(b);
      i_len   = (AW+1)'(l);
      for (int i = 0; i < l; i++) begin
         q_addr.push_back(AW'((b + i) % DEPTH));
         q_data.push_back(mem[(b + i) % DEPTH]);
         q_last.push_back(i == l - 1);
      end
      @(posedge clk);
      #1;
      i_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (o_done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) fail("done_timeout");
      @(negedge clk);
      chk("done_single_pulse", 32'(o_done), 0);
      chk("idle_busy", 32'(o_busy), 0);
      chk("queue_drained", 32'(q_data.size()), 0);
   endtask

   task automatic check_idle(input string nm);
      chk(nm, 32'({o_busy, o_done, sif.valid, sif.last, rd_en}), 0);
      chk({nm, "_data"}, 32'(sif.data), 0);
   endtask

   initial begin
      int b;
      int l;
      bit seen;
      for (int i = 0; i < DEPTH; i++) mem[i] = RW'($urandom);

      // Reset and quiet idle.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset_state");
      #2 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_after_reset", 32'({o_busy, o_done, sif.valid, sif.last, rd_en}), 0);
      end

      // Basic burst with latency checks.
      rmode = 0;
      start_burst(32'h010, 4);
      @(negedge clk);
      chk("lat_busy_e0", 32'(o_busy), 1);
      chk("lat_rden_e0", 32'(rd_en), 1);
      chk("lat_valid_e0", 32'(sif.valid), 0);
      @(negedge clk);
      chk("lat_valid_e1", 32'(sif.valid), 0);
      @(negedge clk);
      chk("lat_valid_e2", 32'(sif.valid), 1);
      wait_done(50);

      // Wrap at the top of the RAM.
      start_burst(32'h3FE, 4);
      wait_done(50);

      // Toggling ready, then a long stall.
      rmode = 2;
      start_burst(int'($urandom_range(0, DEPTH - 1)), 8);
      repeat (6) @(posedge clk);
      rmode = 3;
      repeat (10) @(posedge clk);
      rmode = 0;
      wait_done(100);

      // Zero-length burst.
      start_burst(32'h055, 0);
      @(negedge clk);
      chk("len0_done", 32'(o_done), 1);
      chk("len0_quiet", 32'({o_busy, rd_en, sif.valid}), 0);
      @(negedge clk);
      chk("len0_done_pulse", 32'(o_done), 0);

      // Start pulses during a burst must be ignored.
      rmode = 1;
      start_burst(32'h200, 12);
      repeat (3) begin
         @(posedge clk);
         #1;
         i_start = 1'b1;
         i_base  = '0;
         i_len   = 11'd5;
         @(posedge clk);
         #1;
         i_start = 1'b0;
      end
      wait_done(300);

      // Random bursts under random backpressure.
      for (int n = 0; n < 8; n++) begin
         rmode = (n % 3 == 0) ? 0 : 1;
         b = int'($urandom_range(0, DEPTH - 1));
         l = int'($urandom_range(1, 40));
         start_burst(b, l);
         wait_done(l * 20 + 50);
      end

      // Full-depth burst reads every word once.
      rmode = 0;
      start_burst(int'($urandom_range(0, DEPTH - 1)), DEPTH);
      wait_done(DEPTH + 100);

      // Asynchronous reset in the middle of a burst.
      rmode = 0;
      l = acc_cnt;
      start_burst(32'h2A0, 8);
      seen = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         #1;
         if (acc_cnt - l >= 3) begin
            seen = 1;
            break;
         end
      end
      if (!seen) fail("midburst_timeout");
      #1 rst_n = 1'b0;
      q_addr.delete();
      q_data.delete();
      q_last.delete();
      rd_cnt = 0;
      acc_cnt = 0;
      stall_prev = 0;
      expect_done = 0;
      #1;
      check_idle("async_reset");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("quiet_release", 32'({o_busy, o_done, sif.valid, rd_en}), 0);
      end
      start_burst(32'h100, 2);
      wait_done(50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
